// File: rtl/frame_capture_ctrl.sv
// Camera frame capture controller: assembles RGB444 pixels from a byte stream
// and writes them into a framebuffer while checking frame geometry.
module frame_capture_ctrl #(
   parameter int H_PIXELS = 640,
   parameter int V_LINES  = 480,
   parameter int ADDR_W   = 19
) (
   input  logic              PCLK,
   input  logic              RST_N,
   input  logic              VSYNC,
   input  logic              HREF,
   input  logic [7:0]        D,
   input  logic              START,
   input  logic              CONTINUOUS,
   input  logic              ABORT,
   output logic              o_WE,
   output logic [ADDR_W-1:0] o_ADDR,
   output logic [11:0]       o_DATA,
   output logic              o_BUSY,
   output logic              o_FRAME_DONE,
   output logic              o_ERR,
   output logic [7:0]        o_FRAME_CNT
);

   localparam int PIX_W  = $clog2(H_PIXELS + 2);
   localparam int LINE_W = $clog2(V_LINES + 2);
   localparam logic [PIX_W-1:0]  PIX_FULL  = PIX_W'(H_PIXELS);
   localparam logic [PIX_W-1:0]  PIX_SAT   = PIX_W'(H_PIXELS + 1);
   localparam logic [LINE_W-1:0] LINE_FULL = LINE_W'(V_LINES);
   localparam logic [LINE_W-1:0] LINE_SAT  = LINE_W'(V_LINES + 1);
   localparam logic [ADDR_W-1:0] H_STEP    = ADDR_W'(H_PIXELS);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_ARMED   = 2'b01,
      ST_CAPTURE = 2'b10
   } state_t;

   state_t              state_r;
   state_t              state_s;
   logic                vsync_r;
   logic                href_r;
   logic                phase_r;
   logic [3:0]          red_r;
   logic [PIX_W-1:0]    pix_cnt_r;
   logic [LINE_W-1:0]   line_cnt_r;
   logic [ADDR_W-1:0]   addr_cnt_r;
   logic [ADDR_W-1:0]   line_base_r;
   logic                we_r;
   logic [ADDR_W-1:0]   addr_r;
   logic [11:0]         data_r;
   logic                busy_r;
   logic                done_r;
   logic                err_r;
   logic [7:0]          frame_cnt_r;

   logic                vsync_fall_s;
   logic                vsync_rise_s;
   logic                href_fall_s;
   logic                arm_s;
   logic                clear_s;
   logic                byte_s;
   logic                line_end_s;
   logic                done_s;
   logic                frame_err_s;
   logic                line_err_s;
   logic                write_s;

   assign vsync_fall_s = vsync_r & ~VSYNC;
   assign vsync_rise_s = ~vsync_r & VSYNC;
   assign href_fall_s  = href_r & ~HREF;

   // State register
   always_ff @(posedge PCLK or negedge RST_N) begin
      if (!RST_N) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state and per-cycle control decode; ABORT overrides everything
   always_comb begin
      state_s     = state_r;
      arm_s       = 1'b0;
      clear_s     = 1'b0;
      byte_s      = 1'b0;
      line_end_s  = 1'b0;
      done_s      = 1'b0;
      frame_err_s = 1'b0;
      if (ABORT) begin
         state_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (START) begin
                  state_s = ST_ARMED;
                  arm_s   = 1'b1;
               end else begin
                  state_s = ST_IDLE;
               end
            end
            ST_ARMED: begin
               if (vsync_fall_s) begin
                  state_s = ST_CAPTURE;
                  clear_s = 1'b1;
               end else begin
                  state_s = ST_ARMED;
               end
            end
            ST_CAPTURE: begin
               byte_s     = HREF;
               line_end_s = href_fall_s;
               if (vsync_rise_s) begin
                  if (line_cnt_r == LINE_FULL) begin
                     done_s = 1'b1;
                  end else begin
                     frame_err_s = 1'b1;
                  end
                  state_s = CONTINUOUS ? ST_ARMED : ST_IDLE;
               end else begin
                  state_s = ST_CAPTURE;
               end
            end
            default: begin
               state_s = ST_IDLE;
            end
         endcase
      end
   end

   // Write qualification: in-bounds pixel whose second byte is present now
   always_comb begin
      write_s    = 1'b0;
      line_err_s = 1'b0;
      if (byte_s && phase_r && (pix_cnt_r < PIX_FULL) &&
          (line_cnt_r < LINE_FULL) && (state_s == ST_CAPTURE)) begin
         write_s = 1'b1;
      end else begin
         write_s = 1'b0;
      end
      if (line_end_s && ((pix_cnt_r != PIX_FULL) || phase_r)) begin
         line_err_s = 1'b1;
      end else begin
         line_err_s = 1'b0;
      end
   end

   // Sync edge registers, byte phase and red nibble
   always_ff @(posedge PCLK or negedge RST_N) begin
      if (!RST_N) begin
         vsync_r <= 1'b0;
         href_r  <= 1'b0;
         phase_r <= 1'b0;
         red_r   <= 4'h0;
      end else begin
         vsync_r <= VSYNC;
         href_r  <= HREF;
         phase_r <= byte_s ? ~phase_r : 1'b0;
         if (byte_s && !phase_r) begin
            red_r <= D[3:0];
         end
      end
   end

   // Geometry counters; the address jumps to the next line base so short
   // lines cannot skew the rest of the frame
   always_ff @(posedge PCLK or negedge RST_N) begin
      if (!RST_N) begin
         pix_cnt_r   <= '0;
         line_cnt_r  <= '0;
         addr_cnt_r  <= '0;
         line_base_r <= '0;
      end else if (clear_s) begin
         pix_cnt_r   <= '0;
         line_cnt_r  <= '0;
         addr_cnt_r  <= '0;
         line_base_r <= '0;
      end else if (line_end_s) begin
         pix_cnt_r   <= '0;
         line_cnt_r  <= (line_cnt_r == LINE_SAT) ? line_cnt_r : line_cnt_r + LINE_W'(1);
         addr_cnt_r  <= line_base_r + H_STEP;
         line_base_r <= line_base_r + H_STEP;
      end else begin
         if (byte_s && phase_r && (pix_cnt_r != PIX_SAT)) begin
            pix_cnt_r <= pix_cnt_r + PIX_W'(1);
         end
         if (write_s) begin
            addr_cnt_r <= addr_cnt_r + ADDR_W'(1);
         end
      end
   end

   // Registered outputs
   always_ff @(posedge PCLK or negedge RST_N) begin
      if (!RST_N) begin
         we_r        <= 1'b0;
         addr_r      <= '0;
         data_r      <= 12'h000;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         err_r       <= 1'b0;
         frame_cnt_r <= 8'h00;
      end else begin
         we_r   <= write_s;
         busy_r <= (state_s != ST_IDLE);
         done_r <= done_s;
         if (write_s) begin
            addr_r <= addr_cnt_r;
            data_r <= {red_r, D};
         end
         if (done_s) begin
            frame_cnt_r <= frame_cnt_r + 8'd1;
         end
         if (arm_s) begin
            err_r <= 1'b0;
         end else if (frame_err_s || line_err_s) begin
            err_r <= 1'b1;
         end
      end
   end

   assign o_WE         = we_r;
   assign o_ADDR       = addr_r;
   assign o_DATA       = data_r;
   assign o_BUSY       = busy_r;
   assign o_FRAME_DONE = done_r;
   assign o_ERR        = err_r;
   assign o_FRAME_CNT  = frame_cnt_r;

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Directed bench for frame_capture_ctrl with a 4x2 frame geometry.
module tb_frame_capture_ctrl;

   localparam int HP = 4;
   localparam int VL = 2;
   localparam int AW = 3;

   logic          PCLK = 1'b0;
   logic          RST_N = 1'b0;
   logic          VSYNC = 1'b1;
   logic          HREF = 1'b0;
   logic [7:0]    D = 8'h00;
   logic          START = 1'b0;
   logic          CONTINUOUS = 1'b0;
   logic          ABORT = 1'b0;
   logic          o_WE;
   logic [AW-1:0] o_ADDR;
   logic [11:0]   o_DATA;
   logic          o_BUSY;
   logic          o_FRAME_DONE;
   logic          o_ERR;
   logic [7:0]    o_FRAME_CNT;

   int checks = 0;
   int errors = 0;
   int we_cnt = 0;
   int done_cnt = 0;
   bit watch_busy = 1'b0;
   bit busy_dropped = 1'b0;
   logic [AW-1:0] addr_q[$];
   logic [11:0]   data_q[$];

   frame_capture_ctrl #(.H_PIXELS(HP), .V_LINES(VL), .ADDR_W(AW)) dut (
      .PCLK(PCLK), .RST_N(RST_N), .VSYNC(VSYNC), .HREF(HREF), .D(D),
      .START(START), .CONTINUOUS(CONTINUOUS), .ABORT(ABORT),
      .o_WE(o_WE), .o_ADDR(o_ADDR), .o_DATA(o_DATA), .o_BUSY(o_BUSY),
      .o_FRAME_DONE(o_FRAME_DONE), .o_ERR(o_ERR), .o_FRAME_CNT(o_FRAME_CNT)
   );

   always #5 PCLK = ~PCLK;

   // Record writes and frame-done pulses mid-cycle
   always @(negedge PCLK) begin
      if (o_WE === 1'b1) begin
         we_cnt++;
         addr_q.push_back(o_ADDR);
         data_q.push_back(o_DATA);
      end
      if (o_FRAME_DONE === 1'b1) done_cnt++;
      if (watch_busy && (o_BUSY !== 1'b1)) busy_dropped = 1'b1;
   end

   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_mon();
      we_cnt = 0;
      done_cnt = 0;
      addr_q.delete();
      data_q.delete();
   endtask

   task automatic send_bytes(input int n);
      HREF = 1'b1;
      for (int i = 0; i < n; i++) begin
         D = (i % 2 == 1) ? 8'hBC : 8'h0A;
         tick();
      end
      HREF = 1'b0;
      D = 8'h00;
   endtask

   task automatic send_line(input int n);
      send_bytes(n);
      tick();
      tick();
   endtask

   task automatic check_outputs_zero(input string tag);
      chk(tag, {5'd0, o_WE, o_ADDR, o_DATA, o_BUSY, o_FRAME_DONE, o_ERR, o_FRAME_CNT}, 32'd0);
   endtask

   initial begin
      // reset state
      tick();
      tick();
      check_outputs_zero("reset_outputs");
      RST_N = 1'b1;
      tick();

      // good frame
      START = 1'b1;
      tick();
      START = 1'b0;
      chk("good_busy_armed", o_BUSY, 32'd1);
      VSYNC = 1'b0;
      tick();
      clear_mon();
      send_line(8);
      send_line(8);
      chk("good_we_count", we_cnt, 32'd8);
      for (int i = 0; i < addr_q.size(); i++) begin
         chk($sformatf("good_addr%0d", i), addr_q[i], i);
         chk($sformatf("good_data%0d", i), data_q[i], 32'hABC);
      end
      chk("good_err", o_ERR, 32'd0);
      chk("good_no_early_done", done_cnt, 32'd0);
      VSYNC = 1'b1;
      tick();
      chk("good_done_pulse", o_FRAME_DONE, 32'd1);
      chk("good_frame_cnt", o_FRAME_CNT, 32'd1);
      tick();
      chk("good_done_one_cycle", o_FRAME_DONE, 32'd0);
      chk("good_idle_busy", o_BUSY, 32'd0);
      chk("good_done_count", done_cnt, 32'd1);

      // short line
      START = 1'b1;
      tick();
      START = 1'b0;
      VSYNC = 1'b0;
      tick();
      clear_mon();
      send_bytes(6);
      chk("short_err_before_fall", o_ERR, 32'd0);
      tick();
      chk("short_err_at_fall", o_ERR, 32'd1);
      tick();
      chk("short_we_count", we_cnt, 32'd3);
      VSYNC = 1'b1;
      tick();
      chk("short_no_done", o_FRAME_DONE, 32'd0);
      tick();
      chk("short_done_count", done_cnt, 32'd0);
      chk("short_frame_cnt", o_FRAME_CNT, 32'd1);

      // long line
      START = 1'b1;
      tick();
      START = 1'b0;
      chk("long_err_cleared_on_arm", o_ERR, 32'd0);
      VSYNC = 1'b0;
      tick();
      clear_mon();
      send_line(10);
      chk("long_we_count", we_cnt, 32'd4);
      for (int i = 0; i < addr_q.size(); i++) begin
         chk($sformatf("long_addr%0d", i), addr_q[i], i);
      end
      chk("long_err", o_ERR, 32'd1);
      VSYNC = 1'b1;
      tick();
      tick();

      // continuous mode over three frames
      CONTINUOUS = 1'b1;
      START = 1'b1;
      tick();
      START = 1'b0;
      watch_busy = 1'b1;
      clear_mon();
      for (int f = 0; f < 3; f++) begin
         addr_q.delete();
         VSYNC = 1'b0;
         tick();
         send_line(8);
         send_line(8);
         chk($sformatf("cont_we_frame%0d", f), addr_q.size(), 32'd8);
         if (addr_q.size() > 0) chk($sformatf("cont_addr0_frame%0d", f), addr_q[0], 32'd0);
         VSYNC = 1'b1;
         tick();
         tick();
      end
      chk("cont_done_count", done_cnt, 32'd3);
      chk("cont_busy_held", busy_dropped, 32'd0);
      chk("cont_frame_cnt", o_FRAME_CNT, 32'd4);
      chk("cont_err", o_ERR, 32'd0);
      watch_busy = 1'b0;

      // abort, mid-line and together with START
      CONTINUOUS = 1'b0;
      ABORT = 1'b1;
      tick();
      ABORT = 1'b0;
      chk("abort_armed_busy", o_BUSY, 32'd0);
      START = 1'b1;
      tick();
      START = 1'b0;
      VSYNC = 1'b0;
      tick();
      clear_mon();
      HREF = 1'b1;
      D = 8'h0A; tick();
      D = 8'hBC; tick();
      D = 8'h0A; tick();
      D = 8'hBC; ABORT = 1'b1; tick();
      ABORT = 1'b0;
      chk("abort_we_low", o_WE, 32'd0);
      chk("abort_busy_low", o_BUSY, 32'd0);
      D = 8'h0A; tick();
      D = 8'hBC; tick();
      D = 8'h0A; tick();
      D = 8'hBC; tick();
      HREF = 1'b0;
      D = 8'h00;
      tick();
      chk("abort_we_count", we_cnt, 32'd1);
      START = 1'b1;
      ABORT = 1'b1;
      tick();
      START = 1'b0;
      ABORT = 1'b0;
      chk("abort_start_same_cycle", o_BUSY, 32'd0);
      tick();
      chk("abort_start_stays_idle", o_BUSY, 32'd0);
      VSYNC = 1'b1;
      tick();

      // reset mid-frame
      START = 1'b1;
      tick();
      START = 1'b0;
      VSYNC = 1'b0;
      tick();
      send_line(8);
      HREF = 1'b1;
      D = 8'h0A; tick();
      D = 8'hBC; tick();
      D = 8'h0A; tick();
      D = 8'hBC; tick();
      RST_N = 1'b0;
      #2;
      check_outputs_zero("midframe_reset_outputs");
      tick();
      tick();
      RST_N = 1'b1;
      HREF = 1'b0;
      D = 8'h00;
      clear_mon();
      tick();
      VSYNC = 1'b1;
      tick();
      VSYNC = 1'b0;
      tick();
      send_line(8);
      VSYNC = 1'b1;
      tick();
      tick();
      chk("post_reset_no_write", we_cnt, 32'd0);
      chk("post_reset_no_done", done_cnt, 32'd0);
      chk("post_reset_idle", o_BUSY, 32'd0);
      START = 1'b1;
      tick();
      START = 1'b0;
      VSYNC = 1'b0;
      tick();
      send_line(8);
      chk("post_reset_we_count", we_cnt, 32'd4);
      if (addr_q.size() > 0) chk("post_reset_addr0", addr_q[0], 32'd0);
      chk("post_reset_frame_cnt", o_FRAME_CNT, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
